// File: rtl/sos_pkg.sv
// Shared encodings for the SOS detection chain: symbol codes from dash_dot,
// letter classification codes and the sequence FSM states.
package sos_pkg;

  // Symbol codes as delivered by dash_dot with sym_ready.
  localparam logic [1:0] SYM_DOT   = 2'b00;
  localparam logic [1:0] SYM_DASH  = 2'b11;
  localparam logic [1:0] SYM_SPACE = 2'b10;
  localparam logic [1:0] SYM_RSVD  = 2'b01;

  // Letter classification codes.
  localparam logic [1:0] LET_OTHER = 2'b00;
  localparam logic [1:0] LET_S     = 2'b01;
  localparam logic [1:0] LET_O     = 2'b10;

  // Sequence FSM states: nothing matched, "S" seen, "S O" seen.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GOT_S  = 2'b01,
    ST_GOT_SO = 2'b10
  } sos_state_t;

endpackage

// File: rtl/morse_letter_assembler.sv
// Groups dot/dash symbols into letters and classifies each closed letter as
// S, O or OTHER.
//
// Handshake: sym_ready is a one-cycle strobe with no back-pressure; sym_code
// is consumed on every rising edge where sym_ready=1 and ignored otherwise.
// letter_valid is a one-cycle pulse, letter_code holds between pulses.
//
// close_now/close_code are the combinational "a letter closes on this edge"
// view, so the sequence FSM can register its result on the same edge as
// letter_valid.
module morse_letter_assembler
  import sos_pkg::*;
#(
  parameter int MAX_SYMS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_ready,
  input  logic [1:0] sym_code,
  output logic       close_now,
  output logic [1:0] close_code,
  output logic       letter_valid,
  output logic [1:0] letter_code
);

  localparam int LEN_W = $clog2(MAX_SYMS + 1);

  // Only letters of exactly three symbols can be S or O, so the shift
  // register keeps the three most recent symbols (1 = dash).
  logic [2:0]       shreg;
  logic [LEN_W-1:0] len;
  logic             poison;
  logic             is_mark;

  // Decode the current strobe and classify the letter being closed.
  always_comb begin
    is_mark    = sym_ready && (sym_code == SYM_DOT || sym_code == SYM_DASH);
    close_now  = sym_ready && (sym_code == SYM_SPACE) &&
                 ((len != '0) || poison);
    close_code = LET_OTHER;
    if (!poison && (len == LEN_W'(3))) begin
      if (shreg == 3'b000) begin
        close_code = LET_S;
      end else if (shreg == 3'b111) begin
        close_code = LET_O;
      end
    end
  end

  // Letter assembly: shift, length count and poison tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      len    <= '0;
      poison <= 1'b0;
    end else if (close_now) begin
      shreg  <= '0;
      len    <= '0;
      poison <= 1'b0;
    end else if (is_mark) begin
      if (len == LEN_W'(MAX_SYMS)) begin
        poison <= 1'b1;
      end else begin
        shreg <= {shreg[1:0], (sym_code == SYM_DASH)};
        len   <= len + LEN_W'(1);
      end
    end else if (sym_ready && (sym_code == SYM_RSVD)) begin
      poison <= 1'b1;
    end
  end

  // Registered letter outputs; the code holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_valid <= 1'b0;
      letter_code  <= LET_OTHER;
    end else begin
      letter_valid <= close_now;
      if (close_now) begin
        letter_code <= close_code;
      end
    end
  end

endmodule

// File: rtl/sos_detector.sv
// SOS detector: assembles Morse letters and flags every S-O-S letter
// sequence, overlapping matches included (SOSOS gives two detections).
// Optional feature macro: SOS_COUNT_EN adds a saturating sos_count output.
// dbg_state exposes the sequence FSM state.
module sos_detector
  import sos_pkg::*;
#(
  parameter int MAX_SYMS = 4,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sym_ready,
  input  logic [1:0]         sym_code,
  output logic               letter_valid,
  output logic [1:0]         letter_code,
  output logic               sos_found,
`ifdef SOS_COUNT_EN
  output logic [COUNT_W-1:0] sos_count,
`endif
  output logic [1:0]         dbg_state
);

  logic       close_now;
  logic [1:0] close_code;
  sos_state_t state;
  sos_state_t next_state;
  logic       found_next;

  morse_letter_assembler #(
    .MAX_SYMS(MAX_SYMS)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_ready   (sym_ready),
    .sym_code    (sym_code),
    .close_now   (close_now),
    .close_code  (close_code),
    .letter_valid(letter_valid),
    .letter_code (letter_code)
  );

  // Sequence FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state advances only when a letter closes; a closing S after "S O"
  // flags a match and leaves the FSM in GOT_S so overlaps are caught.
  always_comb begin
    next_state = state;
    found_next = 1'b0;
    if (close_now) begin
      case (state)
        ST_IDLE: begin
          next_state = (close_code == LET_S) ? ST_GOT_S : ST_IDLE;
        end
        ST_GOT_S: begin
          if (close_code == LET_S) begin
            next_state = ST_GOT_S;
          end else if (close_code == LET_O) begin
            next_state = ST_GOT_SO;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_GOT_SO: begin
          if (close_code == LET_S) begin
            next_state = ST_GOT_S;
            found_next = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Detection pulse, registered on the same edge as letter_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sos_found <= 1'b0;
    end else begin
      sos_found <= found_next;
    end
  end

`ifdef SOS_COUNT_EN
  // Saturating detection counter, updated alongside sos_found.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sos_count <= '0;
    end else if (found_next && (sos_count != '1)) begin
      sos_count <= sos_count + COUNT_W'(1);
    end
  end
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_sos_detector.sv
// Testbench for sos_detector: table-driven S-O-S vectors, hand-written corner
// sequences, and randomized traffic checked against a letter-level model.
module tb_sos_detector;
  import sos_pkg::*;

  localparam int MAX_SYMS = 4;
  localparam int COUNT_W  = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_ready = 1'b0;
  logic [1:0] sym_code = 2'b00;
  logic letter_valid;
  logic [1:0] letter_code;
  logic sos_found;
  logic [1:0] dbg_state;
`ifdef SOS_COUNT_EN
  logic [COUNT_W-1:0] sos_count;
`endif

  always #5 clk = ~clk;

  sos_detector #(
    .MAX_SYMS(MAX_SYMS),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_ready   (sym_ready),
    .sym_code    (sym_code),
    .letter_valid(letter_valid),
    .letter_code (letter_code),
    .sos_found   (sos_found),
`ifdef SOS_COUNT_EN
    .sos_count   (sos_count),
`endif
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int found_pulses  = 0;
  int letter_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: letters as symbol lists, detection from letter history.
  int         sym_q[$];
  bit         m_poison;
  int         hist[$];
  logic [1:0] m_lc;
  bit         m_lv;
  bit         m_found;
  int         m_count;

  task automatic model_reset();
    sym_q.delete();
    hist.delete();
    m_poison = 0;
    m_lc     = LET_OTHER;
    m_lv     = 0;
    m_found  = 0;
    m_count  = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] c);
    int n;
    int dots;
    int dashes;
    logic [1:0] code;
    m_lv    = 0;
    m_found = 0;
    if (!v) return;
    if (c == SYM_DOT || c == SYM_DASH) begin
      if (sym_q.size() == MAX_SYMS) m_poison = 1;
      else sym_q.push_back((c == SYM_DASH) ? 1 : 0);
    end else if (c == SYM_RSVD) begin
      m_poison = 1;
    end else if (sym_q.size() != 0 || m_poison) begin
      dots = 0;
      dashes = 0;
      foreach (sym_q[i]) begin
        if (sym_q[i] == 1) dashes++;
        else dots++;
      end
      code = LET_OTHER;
      if (!m_poison && dots == 3 && dashes == 0) code = LET_S;
      if (!m_poison && dashes == 3 && dots == 0) code = LET_O;
      m_lv = 1;
      m_lc = code;
      hist.push_back(code);
      n = hist.size();
      if (n >= 3 && hist[n-3] == LET_S && hist[n-2] == LET_O && hist[n-1] == LET_S) begin
        m_found = 1;
        if (m_count < (1 << COUNT_W) - 1) m_count++;
      end
      sym_q.delete();
      m_poison = 0;
    end
  endtask

  // Driver: one cycle, inputs driven at negedge, outputs compared next negedge.
  task automatic step(input bit v, input logic [1:0] c);
    sym_ready = v;
    sym_code  = c;
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
    check("letter_valid", int'(letter_valid), int'(m_lv));
    check("letter_code", int'(letter_code), int'(m_lc));
    check("sos_found", int'(sos_found), int'(m_found));
`ifdef SOS_COUNT_EN
    check("sos_count", int'(sos_count), m_count);
`endif
    found_pulses  += int'(sos_found);
    letter_pulses += int'(letter_valid);
  endtask

  task automatic send_letter(input logic [1:0] kind);
    logic [1:0] s;
    s = (kind == LET_S) ? SYM_DOT : SYM_DASH;
    for (int i = 0; i < 3; i++) step(1'b1, s);
    step(1'b1, SYM_SPACE);
  endtask

  typedef struct {
    bit         v;
    logic [1:0] c;
    bit         lv;
    logic [1:0] lc;
    bit         f;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int r;
    logic [1:0] sc;
    model_reset();

    // Reset state
    @(negedge clk);
    check("reset_letter_valid", int'(letter_valid), 0);
    check("reset_letter_code", int'(letter_code), 0);
    check("reset_sos_found", int'(sos_found), 0);
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
`ifdef SOS_COUNT_EN
    check("reset_sos_count", int'(sos_count), 0);
`endif
    rst_n = 1'b1;

    // Table: idle, S, O, S, idle
    tbl[0] = '{1'b0, SYM_SPACE, 1'b0, LET_OTHER, 1'b0};
    for (int i = 1; i <= 3; i++) tbl[i] = '{1'b1, SYM_DOT, 1'b0, LET_OTHER, 1'b0};
    tbl[4] = '{1'b1, SYM_SPACE, 1'b1, LET_S, 1'b0};
    for (int i = 5; i <= 7; i++) tbl[i] = '{1'b1, SYM_DASH, 1'b0, LET_S, 1'b0};
    tbl[8] = '{1'b1, SYM_SPACE, 1'b1, LET_O, 1'b0};
    for (int i = 9; i <= 11; i++) tbl[i] = '{1'b1, SYM_DOT, 1'b0, LET_O, 1'b0};
    tbl[12] = '{1'b1, SYM_SPACE, 1'b1, LET_S, 1'b1};
    tbl[13] = '{1'b0, SYM_DASH, 1'b0, LET_S, 1'b0};
    found_pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].c);
      check("tbl_letter_valid", int'(letter_valid), int'(tbl[i].lv));
      check("tbl_letter_code", int'(letter_code), int'(tbl[i].lc));
      check("tbl_sos_found", int'(sos_found), int'(tbl[i].f));
    end
    check("tbl_found_total", found_pulses, 1);
`ifdef SOS_COUNT_EN
    check("tbl_sos_count", int'(sos_count), 1);
`endif

    // SOSOS: overlapping detections
    found_pulses = 0;
    send_letter(LET_S); send_letter(LET_O); send_letter(LET_S);
    send_letter(LET_O); send_letter(LET_S);
    check("sosos_found_total", found_pulses, 2);

    // SOOS: no detection
    found_pulses = 0;
    letter_pulses = 0;
    send_letter(LET_S); send_letter(LET_O); send_letter(LET_O); send_letter(LET_S);
    check("soos_found_total", found_pulses, 0);
    check("soos_letters", letter_pulses, 4);

    // Overflow: five dots poison the letter, then SOS still detected
    for (int i = 0; i < 5; i++) step(1'b1, SYM_DOT);
    step(1'b1, SYM_SPACE);
    check("overflow_valid", int'(letter_valid), 1);
    check("overflow_code", int'(letter_code), int'(LET_OTHER));
    found_pulses = 0;
    send_letter(LET_S); send_letter(LET_O); send_letter(LET_S);
    check("after_overflow_found", found_pulses, 1);

    // Reserved code mid-letter, then bare spaces
    step(1'b1, SYM_DOT); step(1'b1, SYM_RSVD); step(1'b1, SYM_DOT);
    step(1'b1, SYM_SPACE);
    check("rsvd_code", int'(letter_code), int'(LET_OTHER));
    letter_pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b1, SYM_SPACE);
    check("spaces_no_letter", letter_pulses, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: send_letter(LET_S);
        1: send_letter(LET_O);
        2: begin
          sc = 2'($urandom_range(0, 3));
          step(1'b1, sc);
        end
        3: step(1'b1, SYM_SPACE);
        default: begin
          sc = 2'($urandom_range(0, 3));
          step(1'b0, sc);
        end
      endcase
    end
    step(1'b1, SYM_SPACE);

    // Reset mid-letter discards the partial letter
    step(1'b1, SYM_DOT);
    step(1'b1, SYM_DOT);
    sym_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_letter_valid", int'(letter_valid), 0);
    check("midrst_letter_code", int'(letter_code), 0);
    check("midrst_sos_found", int'(sos_found), 0);
    model_reset();
    @(negedge clk);
    check("midrst_hold_valid", int'(letter_valid), 0);
    rst_n = 1'b1;
    letter_pulses = 0;
    step(1'b0, SYM_SPACE);
    check("release_no_pulse", letter_pulses, 0);
    step(1'b1, SYM_DOT);
    step(1'b1, SYM_SPACE);
    check("after_rst_valid", int'(letter_valid), 1);
    check("after_rst_code", int'(letter_code), int'(LET_OTHER));
    check("after_rst_letters", letter_pulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sos_detector.md
Name: sos_detector

Overview:
- Consumes the dot/dash/space symbol stream from dash_dot and groups symbols into letters at each space.
- Classifies each letter as S, O or OTHER.
- Runs a sequence FSM that flags every S-O-S pattern.
- Last stage of the SOS chain; its outputs drive the bench and any indicator logic.

Parameters:
MAX_SYMS, 4, maximum symbols per letter held in the assembler; more than this poisons the letter (minimum 3)
COUNT_W, 8, width of the optional detection counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
sym_ready  input  1  one-cycle strobe from dash_dot: sym_code valid this cycle
sym_code  input  2  symbol: 2'b00 dot, 2'b11 dash, 2'b10 space (letter end), 2'b01 reserved/invalid
letter_valid  output  1  one-cycle pulse: letter_code valid
letter_code  output  2  2'b01 S, 2'b10 O, 2'b00 OTHER; holds last value between pulses
sos_found  output  1  one-cycle pulse, coincident with letter_valid of the closing S
sos_count  output  COUNT_W  saturating detection count (present only with SOS_COUNT_EN)

Behaviour:
- Reset (async, rst_n=0):
  - letter_valid=0, letter_code=2'b00, sos_found=0, sos_count=0.
  - Symbol length counter=0, poison flag=0, FSM=IDLE.
- A symbol is consumed on each rising clk edge with sym_ready=1. sym_code is ignored when sym_ready=0.
- Dot/dash:
  - Shifted into the symbol register; length counter increments.
  - When length already equals MAX_SYMS, the symbol is dropped, poison is set, and the length counter does not increment.
- Reserved code 2'b01 sets poison. The length counter is unchanged.
- Space with length=0 and poison=0 (repeated spaces or a word gap): ignored. No pulse, FSM unchanged.
- Space otherwise closes the letter:
  - Classification:
    - S = length 3, all dots, poison=0.
    - O = length 3, all dashes, poison=0.
    - Everything else, including a poisoned empty letter, = OTHER.
  - Length counter and poison clear on the same edge.
- Latency: space consumed at edge N → letter_valid/letter_code/sos_found registered at edge N and high until edge N+1. A new symbol may arrive at edge N+1; back-to-back strobes are legal every cycle.
- Sequence FSM (advances only on letter close):
  - IDLE: S→GOT_S; O/OTHER→IDLE.
  - GOT_S: S→GOT_S; O→GOT_SO; OTHER→IDLE.
  - GOT_SO: S→GOT_S with sos_found=1 (overlap: SOSOS gives 2 detections); O/OTHER→IDLE.
- sos_found is never asserted without letter_valid in the same cycle.
- Reset mid-letter: the partial letter is discarded. No pulse is emitted on reset release.

Optional Feature:
- Macro: SOS_COUNT_EN.
- Defined:
  - sos_count port exists.
  - Increments on each sos_found cycle and saturates at all-ones (no wrap).
  - Async reset to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package sos_pkg:
  - Symbol encodings SYM_DOT/SYM_DASH/SYM_SPACE/SYM_RSVD.
  - Letter codes LET_OTHER/LET_S/LET_O.
  - FSM state encodings ST_IDLE/ST_GOT_S/ST_GOT_SO.
- Sub-module morse_letter_assembler:
  - Contains the shift register, length counter, poison flag and classification.
  - Outputs registered letter_valid/letter_code.
- Top sos_detector: instantiates the assembler and holds the sequence FSM plus the optional counter.

Test Plan:
- Send . . . sp - - - sp . . . sp → letter_code S,O,S; sos_found=1 exactly once, in the same cycle as the third letter_valid; sos_count=1.
- Send S O S O S (letters separated by spaces) → sos_found pulses 2 times (3rd and 5th letters); sos_count=2.
- Send S O O S → 4 letter_valid pulses (S,O,O,S), sos_found never asserted.
- Send . . . . . sp → one letter_valid with letter_code=OTHER (overflow at MAX_SYMS=4). Then S O S → detection still occurs.
- Send . 01 . sp (reserved code mid-letter) → OTHER. Send sp sp sp alone → no letter_valid pulses.
- Send . . (partial letter), pull rst_n low mid-cycle, release, send . sp → outputs 0 during reset; single letter_valid with OTHER (length 1), no stale symbols.
